// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide/accumulate engine.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  // op_i[IS_UNSIGNED] set selects the unsigned variant; op_i[2:1] is the op class
  localparam int IS_UNSIGNED = 0;

  localparam logic [1:0] CLS_MUL  = 2'b00;
  localparam logic [1:0] CLS_DIV  = 2'b01;
  localparam logic [1:0] CLS_MADD = 2'b10;
  localparam logic [1:0] CLS_MSUB = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIXUP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Only instantiated when MULDIV_DIV_EN is defined.
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             annul,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             active;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder and try the subtract
  assign trial     = {rem, quo[WIDTH-1]} - {1'b0, dvs};
  assign done      = active & (cnt == CW'(1));
  assign quotient  = quo;
  assign remainder = rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
    end else if (annul) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CW'(WIDTH);
      quo    <= dividend;
      rem    <= '0;
      dvs    <= divisor;
    end else if (active) begin
      cnt <= cnt - CW'(1);
      if (done) active <= 1'b0;
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV/MADD/MSUB engine with a {HI,LO} result.
// Define MULDIV_DIV_EN to build in the divider; otherwise DIV/DIVU complete with zero.
//   state | meaning
//   IDLE  | waiting for start
//   MUL   | shift-add, MUL_BPC multiplier bits per cycle
//   DIV   | restoring divider running
//   FIXUP | sign correction, accumulate, register result
//   DONE  | one-cycle valid; may accept the next start
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               result_valid_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               div_zero_o,
  output logic               stallreq_o
);
  localparam int K  = WIDTH / MUL_BPC;
  localparam int CW = $clog2(K + 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand, prod, hilo_q, partial, prod_s, res;
  logic               a_neg, b_neg, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign a_neg      = ~op_i[IS_UNSIGNED] & opa_i[WIDTH-1];
  assign b_neg      = ~op_i[IS_UNSIGNED] & opb_i[WIDTH-1];
  assign a_mag      = a_neg ? -opa_i : opa_i;
  assign b_mag      = b_neg ? -opb_i : opb_i;
  assign accept     = start_i & ~annul_i & ((state == ST_IDLE) | (state == ST_DONE));
  assign stallreq_o = start_i & ~result_valid_o;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] a_q, div_quo, div_rem;
  logic             neg_r, dz_q, div_done, div_start;

  assign div_start = accept & (op_i[2:1] == CLS_DIV) & (opb_i != '0);

  muldiv_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .annul     (annul_i),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );
`endif

  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BPC; j++)
      if (mplier[j]) partial = partial + (mcand << j);
  end

  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    res = '0;
    case (op_q[2:1])
      CLS_MUL:  res = prod_s;
      CLS_MADD: res = hilo_q + prod_s;
      CLS_MSUB: res = hilo_q - prod_s;
      default: begin
`ifdef MULDIV_DIV_EN
        // Remainder follows the dividend sign, quotient the sign difference
        if (dz_q) res = {a_q, {WIDTH{1'b1}}};
        else      res = {neg_r ? -div_rem : div_rem, neg_q ? -div_quo : div_quo};
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      op_q           <= '0;
      neg_q          <= 1'b0;
      mplier         <= '0;
      mcand          <= '0;
      prod           <= '0;
      hilo_q         <= '0;
      busy_o         <= 1'b0;
      result_valid_o <= 1'b0;
      hi_o           <= '0;
      lo_o           <= '0;
      div_zero_o     <= 1'b0;
`ifdef MULDIV_DIV_EN
      a_q            <= '0;
      neg_r          <= 1'b0;
      dz_q           <= 1'b0;
`endif
    end else if (annul_i) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      busy_o         <= 1'b0;
      result_valid_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          result_valid_o <= 1'b0;
          busy_o         <= 1'b0;
          state          <= ST_IDLE;
          if (accept) begin
            op_q   <= op_i;
            hilo_q <= hilo_i;
            neg_q  <= a_neg ^ b_neg;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            prod   <= '0;
            busy_o <= 1'b1;
            if (op_i[2:1] == CLS_DIV) begin
`ifdef MULDIV_DIV_EN
              a_q   <= opa_i;
              neg_r <= a_neg;
              dz_q  <= (opb_i == '0);
              state <= (opb_i == '0) ? ST_FIXUP : ST_DIV;
`else
              state <= ST_FIXUP;
`endif
            end else begin
              state <= ST_MUL;
              cnt   <= CW'(K);
            end
          end
        end
        ST_MUL: begin
          prod   <= prod + partial;
          mcand  <= mcand << MUL_BPC;
          mplier <= mplier >> MUL_BPC;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_FIXUP;
        end
`ifdef MULDIV_DIV_EN
        ST_DIV: begin
          if (div_done) state <= ST_FIXUP;
        end
`endif
        ST_FIXUP: begin
          {hi_o, lo_o}   <= res;
          busy_o         <= 1'b0;
          result_valid_o <= 1'b1;
          state          <= ST_DONE;
`ifdef MULDIV_DIV_EN
          div_zero_o     <= (op_q[2:1] == CLS_DIV) & dz_q;
`else
          div_zero_o     <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: BPC=1 and BPC=4 engines share stimulus and are compared
// every cycle against a transaction-level arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [63:0] hilo = '0;
  logic [1:0]  busy, valid, dz, stall;
  logic [31:0] hi [2];
  logic [31:0] lo [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .MUL_BPC(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opa_i(opa), .opb_i(opb),
    .hilo_i(hilo), .annul_i(annul), .busy_o(busy[0]), .result_valid_o(valid[0]),
    .hi_o(hi[0]), .lo_o(lo[0]), .div_zero_o(dz[0]), .stallreq_o(stall[0])
  );

  muldiv_unit #(.WIDTH(W), .MUL_BPC(4)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opa_i(opa), .opb_i(opb),
    .hilo_i(hilo), .annul_i(annul), .busy_o(busy[1]), .result_valid_o(valid[1]),
    .hi_o(hi[1]), .lo_o(lo[1]), .div_zero_o(dz[1]), .stallreq_o(stall[1])
  );

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Result {div_zero, hi, lo} from plain 64-bit arithmetic
  function automatic logic [64:0] model_op(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] h);
    logic [63:0] p, r;
    logic        z;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z  = 1'b0;
    if (o[0]) p = {32'h0, a} * {32'h0, b};
    else      p = sa * sb;
    case (o[2:1])
      2'b00:   r = p;
      2'b10:   r = h + p;
      2'b11:   r = h - p;
      default: begin
        r = '0;
        if (DIV_EN) begin
          if (b == 0) begin
            r = {a, 32'hFFFF_FFFF};
            z = 1'b1;
          end else if (o[0]) r = {a % b, a / b};
          else               r = {32'(sa % sb), 32'(sa / sb)};
        end
      end
    endcase
    return {z, r};
  endfunction

  function automatic int lat_of(input int d, input logic [2:0] o, input logic [31:0] b);
    if (o[2:1] == 2'b01) return (DIV_EN && b != 0) ? W + 2 : 2;
    return ((d == 0) ? W : W / 4) + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // Transaction model: an accepted op completes lat_of() cycles after its start cycle
  int          cyc = 0;
  bit          pend [2];
  int          tv [2];
  logic [64:0] pres [2];
  logic [64:0] held [2] = '{65'd0, 65'd0};
  bit          vnow;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        pend[d] = 1'b0;
        held[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        vnow = pend[d] && (cyc == tv[d]);
        if (vnow) held[d] = pres[d];
        if (annul) pend[d] = 1'b0;
        else if (start && (!pend[d] || vnow)) begin
          pres[d] = model_op(op, opa, opb, hilo);
          tv[d]   = cyc + lat_of(d, op, opb);
          pend[d] = 1'b1;
        end else if (vnow) pend[d] = 1'b0;
      end
    end
    cyc++;
  end

  bit          ev, eb;
  logic [64:0] cur;

  always begin
    @(posedge clk);
    #3;
    for (int d = 0; d < 2; d++) begin
      ev  = pend[d] && (cyc == tv[d]);
      eb  = pend[d] && (cyc < tv[d]);
      cur = ev ? pres[d] : held[d];
      chk($sformatf("busy%0d@%0d", d, cyc), busy[d], eb);
      chk($sformatf("valid%0d@%0d", d, cyc), valid[d], ev);
      chk($sformatf("hi%0d@%0d", d, cyc), hi[d], cur[63:32]);
      chk($sformatf("lo%0d@%0d", d, cyc), lo[d], cur[31:0]);
      chk($sformatf("dz%0d@%0d", d, cyc), dz[d], cur[64]);
      chk($sformatf("stall%0d@%0d", d, cyc), stall[d], start & ~ev);
    end
  end

  // Called at a negedge; returns at the negedge of the BPC=1 engine's valid cycle
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] h, input logic [63:0] exp_r,
                        input logic exp_z, input int exp_l1, input int exp_l4);
    int l1, l4, bc;
    bit s4;
    start = 1'b1; op = o; opa = a; opb = b; hilo = h;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); opa = $urandom; opb = $urandom; hilo = {$urandom, $urandom};
    l1 = -1; l4 = -1; bc = 0; s4 = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      if (!s4 && valid[1]) begin
        s4 = 1'b1;
        l4 = n;
      end
      if (valid[0]) begin
        l1 = n;
        break;
      end
      if (busy[0]) bc++;
      @(negedge clk);
    end
    chk({nm, "_lat1"}, l1, exp_l1);
    chk({nm, "_lat4"}, l4, exp_l4);
    chk({nm, "_busycyc"}, bc, exp_l1 - 1);
    chk({nm, "_hilo1"}, {hi[0], lo[0]}, exp_r);
    chk({nm, "_hilo4"}, {hi[1], lo[1]}, exp_r);
    chk({nm, "_dz1"}, dz[0], exp_z);
  endtask

  initial begin
    int dl, vc;
    dl = DIV_EN ? 34 : 2;

    chk("model_mult", model_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 64'd0), {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    chk("model_msub", model_op(OP_MSUB, 32'd3, 32'd4, 64'd5), {1'b0, 64'hFFFF_FFFF_FFFF_FFF9});
    chk("model_multu", model_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'd0), {1'b0, 64'h1_FFFF_FFFE});

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 2'b00);
    chk("rst_valid", valid, 2'b00);
    chk("rst_hilo", {hi[0], lo[0]}, 64'd0);
    chk("rst_dz", dz, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 34, 10);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'h0000_0001_FFFF_FFFE, 1'b0, 34, 10);
    run_op("madd", OP_MADD, 32'd3, 32'd4, 64'd5, 64'h11, 1'b0, 34, 10);
    run_op("msub_b2b", OP_MSUB, 32'd3, 32'd4, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 34, 10);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0,
           DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFD : 64'd0, 1'b0, dl, dl);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0,
           DIV_EN ? 64'h0000_0000_8000_0000 : 64'd0, 1'b0, dl, dl);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 64'd0,
           DIV_EN ? {32'd2, 32'd14} : 64'd0, 1'b0, dl, dl);
    run_op("div_zero", OP_DIV, 32'h1234, 32'd0, 64'd0,
           DIV_EN ? 64'h0000_1234_FFFF_FFFF : 64'd0, DIV_EN, 2, 2);
    run_op("mult_clr", OP_MULT, 32'd5, 32'd7, 64'd0, 64'd35, 1'b0, 34, 10);

    // Annul a MULTU in its cycle 10
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; opa = 32'd9; opb = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    chk("annul_busy", busy[0], 1'b0);
    chk("annul_hold", {hi[0], lo[0]}, 64'd35);
    vc = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid[0]) vc++;
    end
    chk("annul_novalid", vc, 0);

    start = 1'b1; annul = 1'b1; op = OP_MULT; opa = 32'd2; opb = 32'd3;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    chk("start_annul_busy", busy, 2'b00);
    repeat (3) @(negedge clk);
    chk("start_annul_hold", {hi[0], lo[0]}, 64'd35);

    // Asynchronous reset in the middle of a divide
    start = 1'b1; op = OP_DIV; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 2'b00);
    chk("midrst_valid", valid, 2'b00);
    chk("midrst_hilo1", {hi[0], lo[0]}, 64'd0);
    chk("midrst_hilo4", {hi[1], lo[1]}, 64'd0);
    chk("midrst_dz", dz, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(3) != 0);
      annul = ($urandom_range(149) == 0);
      op    = 3'($urandom);
      opa   = pick();
      opb   = pick();
      hilo  = {pick(), pick()};
    end
    start = 1'b0;
    annul = 1'b0;
    repeat (50) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
